// File: rtl/rep_chk_pkg.sv
// Shared helpers for the repeated-sequence checker: popcount and saturating add.
package rep_chk_pkg;

  localparam int unsigned VEC_W = 64;

  function automatic int unsigned popcount(input logic [VEC_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < VEC_W; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

  // Clamp a + b to the largest value representable in w bits.
  function automatic logic [VEC_W-1:0] sat_add(input logic [VEC_W-1:0] a,
                                               input logic [VEC_W-1:0] b,
                                               input int unsigned      w);
    logic [VEC_W:0]   sum;
    logic [VEC_W-1:0] maxv;
    maxv = (w >= VEC_W) ? '1 : ((VEC_W'(1) << w) - VEC_W'(1));
    sum  = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, maxv}) begin
      return maxv;
    end
    return sum[VEC_W-1:0];
  endfunction

endpackage

// File: rtl/rep_chk_lane.sv
// One checker lane: age-shift vector of live attempts, registered pass/fail
// pulses and saturating pass/fail counters.
module rep_chk_lane
  import rep_chk_pkg::*;
#(
  parameter int unsigned DELAY = 1,
  parameter int unsigned REPS  = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             trig_i,
  input  logic             cond_i,
  output logic             pass_o,
  output logic             fail_o,
  output logic             fail_next_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o
);

  localparam int unsigned W  = DELAY + REPS;
  // Stored bit j holds an attempt that is j+1 edges old when the next edge is evaluated,
  // so ages 1..W-1 need only W-1 storage bits.
  localparam int unsigned AW = W - 1;

  logic [AW-1:0]    age_q, age_d;
  logic [AW-1:0]    chk_mask, killed, surv;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;

  always_comb begin
    chk_mask = '0;
    for (int unsigned j = 0; j < AW; j++) begin
      chk_mask[j] = (j + 1 >= DELAY);
    end
    killed = cond_i ? '0 : (age_q & chk_mask);
    surv   = age_q & ~killed;
    pass_d = cond_i & age_q[AW-1];
    fail_d = |killed;

    age_d    = '0;
    age_d[0] = trig_i & en_i;
    for (int unsigned j = 1; j < AW; j++) begin
      age_d[j] = surv[j-1];
    end

    pcnt_d = clr_i ? '0 : CNT_W'(sat_add(VEC_W'(pcnt_q), VEC_W'(pass_d), CNT_W));
    fcnt_d = clr_i ? '0 : CNT_W'(sat_add(VEC_W'(fcnt_q),
                                         VEC_W'(popcount(VEC_W'(killed))), CNT_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q  <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      pcnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      age_q  <= age_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      pcnt_q <= pcnt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign fail_next_o = fail_d;
  assign busy_o      = |age_q;
  assign pass_cnt_o  = pcnt_q;
  assign fail_cnt_o  = fcnt_q;

endmodule

// File: rtl/rep_seq_checker.sv
// Multi-lane checker for "trig |-> ##DELAY cond[*REPS]" with per-attempt
// pass/fail pulses, saturating counters and a sticky error flag.
module rep_seq_checker
  import rep_chk_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DELAY  = 1,
  parameter int unsigned REPS   = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic [NUM_CH-1:0]       trig,
  input  logic [NUM_CH-1:0]       cond,
  output logic [NUM_CH-1:0]       pass,
  output logic [NUM_CH-1:0]       fail,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH*CNT_W-1:0] pass_cnt,
  output logic [NUM_CH*CNT_W-1:0] fail_cnt,
  output logic                    err_sticky
);

  logic [NUM_CH-1:0] fail_next;
  logic              err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    rep_chk_lane #(
      .DELAY (DELAY),
      .REPS  (REPS),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .en_i        (en),
      .clr_i       (clr),
      .trig_i      (trig[i]),
      .cond_i      (cond[i]),
      .pass_o      (pass[i]),
      .fail_o      (fail[i]),
      .fail_next_o (fail_next[i]),
      .busy_o      (busy[i]),
      .pass_cnt_o  (pass_cnt[i*CNT_W +: CNT_W]),
      .fail_cnt_o  (fail_cnt[i*CNT_W +: CNT_W])
    );
  end

  // Set tracks the same edge that registers the fail pulse, and beats clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (|fail_next) begin
      err_q <= 1'b1;
    end else if (clr) begin
      err_q <= 1'b0;
    end
  end

  assign err_sticky = err_q;

endmodule

// File: tb/tb_rep_seq_checker.sv
// Bench for rep_seq_checker: hand-written vector table, corner sequences and
// randomized traffic against an attempt-list reference model.
module tb_rep_seq_checker;

  localparam int NCH  = 2;
  localparam int DLY  = 1;
  localparam int RP   = 3;
  localparam int CW   = 4;
  localparam int WW   = DLY + RP;
  localparam int CMAX = 15;

  logic                clk = 1'b0;
  logic                rst, en, clr;
  logic [NCH-1:0]      trig, cond;
  logic [NCH-1:0]      pass, fail, busy;
  logic [NCH*CW-1:0]   pass_cnt, fail_cnt;
  logic                err_sticky;

  always #5 clk = ~clk;

  rep_seq_checker #(
    .NUM_CH (NCH),
    .DELAY  (DLY),
    .REPS   (RP),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .trig       (trig),
    .cond       (cond),
    .pass       (pass),
    .fail       (fail),
    .busy       (busy),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt),
    .err_sticky (err_sticky)
  );

  // Reference model: a list of live attempts, each remembered by lane and start edge.
  typedef struct {
    int lane;
    int start;
  } att_t;

  att_t           q[$];
  int             edge_n = 0;
  int             m_pc[NCH];
  int             m_fc[NCH];
  logic [NCH-1:0] m_pass, m_fail, m_busy;
  logic           m_err;

  int vectors     = 0;
  int miscompares = 0;

  task automatic model_edge();
    att_t nq[$];
    int   kills[NCH];
    int   passes[NCH];
    int   age;
    int   tot;
    if (rst) begin
      q.delete();
      for (int l = 0; l < NCH; l++) begin
        m_pc[l] = 0;
        m_fc[l] = 0;
      end
      m_pass = '0;
      m_fail = '0;
      m_busy = '0;
      m_err  = 1'b0;
      edge_n++;
      return;
    end
    for (int l = 0; l < NCH; l++) begin
      kills[l]  = 0;
      passes[l] = 0;
    end
    foreach (q[k]) begin
      age = edge_n - q[k].start;
      if (age >= DLY && age <= WW - 1 && !cond[q[k].lane]) kills[q[k].lane]++;
      else if (age == WW - 1) passes[q[k].lane]++;
      else nq.push_back(q[k]);
    end
    for (int l = 0; l < NCH; l++) begin
      if (trig[l] && en) nq.push_back('{l, edge_n});
    end
    q   = nq;
    tot = 0;
    m_busy = '0;
    foreach (q[k]) m_busy[q[k].lane] = 1'b1;
    for (int l = 0; l < NCH; l++) begin
      m_pass[l] = (passes[l] > 0);
      m_fail[l] = (kills[l] > 0);
      m_pc[l]   = clr ? 0 : ((m_pc[l] + passes[l] > CMAX) ? CMAX : m_pc[l] + passes[l]);
      m_fc[l]   = clr ? 0 : ((m_fc[l] + kills[l] > CMAX) ? CMAX : m_fc[l] + kills[l]);
      tot += kills[l];
    end
    if (tot > 0) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    edge_n++;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
    end
  endtask

  task automatic check_model();
    logic [NCH*CW-1:0] pce, fce;
    for (int l = 0; l < NCH; l++) begin
      pce[l*CW +: CW] = CW'(m_pc[l]);
      fce[l*CW +: CW] = CW'(m_fc[l]);
    end
    chk("model.pass",     64'(pass),       64'(m_pass));
    chk("model.fail",     64'(fail),       64'(m_fail));
    chk("model.busy",     64'(busy),       64'(m_busy));
    chk("model.pass_cnt", 64'(pass_cnt),   64'(pce));
    chk("model.fail_cnt", 64'(fail_cnt),   64'(fce));
    chk("model.err",      64'(err_sticky), 64'(m_err));
  endtask

  task automatic step(input logic r, input logic e, input logic c,
                      input logic [NCH-1:0] t, input logic [NCH-1:0] cd);
    rst  = r;
    en   = e;
    clr  = c;
    trig = t;
    cond = cd;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  typedef struct {
    logic           en;
    logic           clr;
    logic [NCH-1:0] trig;
    logic [NCH-1:0] cond;
    logic [NCH-1:0] xp;
    logic [NCH-1:0] xf;
    logic [NCH-1:0] xb;
    logic           xe;
  } vec_t;

  vec_t tbl[32];

  initial begin
    tbl[0]  = '{1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 0};
    tbl[1]  = '{1, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 0};
    tbl[2]  = '{1, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 0};
    tbl[3]  = '{1, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0};
    tbl[4]  = '{1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0};
    tbl[5]  = '{1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 0};
    tbl[6]  = '{1, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 0};
    tbl[7]  = '{1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1};
    tbl[8]  = '{1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1};
    tbl[9]  = '{1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1};
    tbl[10] = '{1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 1};
    tbl[11] = '{1, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 1};
    tbl[12] = '{1, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 1};
    tbl[13] = '{1, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1};
    tbl[14] = '{1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1};
    tbl[15] = '{1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1};
    tbl[16] = '{1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 1};
    tbl[17] = '{1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 1};
    tbl[18] = '{1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1};
    tbl[19] = '{1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1};
    tbl[20] = '{1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 1};
    tbl[21] = '{1, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 1};
    tbl[22] = '{1, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 1};
    tbl[23] = '{1, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 1};
    tbl[24] = '{1, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1};
    tbl[25] = '{1, 0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 1};
    tbl[26] = '{1, 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 1};
    tbl[27] = '{1, 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 1};
    tbl[28] = '{1, 0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 1};
    tbl[29] = '{1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0};
    tbl[30] = '{0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 0};
    tbl[31] = '{0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0};

    rst = 1'b1; en = 1'b0; clr = 1'b0; trig = '0; cond = '0;
    step(1, 0, 0, 2'b00, 2'b00);
    step(1, 0, 0, 2'b00, 2'b00);
    chk("reset.outputs", 64'({pass, fail, busy, err_sticky}), 64'(0));
    chk("reset.counters", 64'({pass_cnt, fail_cnt}), 64'(0));

    for (int i = 0; i < 32; i++) begin
      step(0, tbl[i].en, tbl[i].clr, tbl[i].trig, tbl[i].cond);
      chk($sformatf("tbl%0d.pass", i), 64'(pass),       64'(tbl[i].xp));
      chk($sformatf("tbl%0d.fail", i), 64'(fail),       64'(tbl[i].xf));
      chk($sformatf("tbl%0d.busy", i), 64'(busy),       64'(tbl[i].xb));
      chk($sformatf("tbl%0d.err", i),  64'(err_sticky), 64'(tbl[i].xe));
      if (i == 28) begin
        chk("tbl.pass_cnt", 64'(pass_cnt), 64'({4'd1, 4'd4}));
        chk("tbl.fail_cnt", 64'(fail_cnt), 64'({4'd0, 4'd5}));
      end
    end

    // Reset in the middle of an attempt: nothing reported afterwards.
    step(0, 1, 0, 2'b01, 2'b00);
    step(0, 1, 0, 2'b00, 2'b01);
    step(1, 1, 0, 2'b00, 2'b00);
    chk("rstmid.busy", 64'(busy), 64'(0));
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 2'b00, 2'b00);
      chk("rstmid.pulses", 64'({pass, fail}), 64'(0));
    end
    chk("rstmid.counters", 64'({pass_cnt, fail_cnt}), 64'(0));

    // Saturation: continuous triggers with cond held high.
    for (int i = 0; i < 24; i++) step(0, 1, 0, 2'b01, 2'b01);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 2'b00, 2'b01);
    chk("sat.pass_cnt0", 64'(pass_cnt[CW-1:0]), 64'(CMAX));

    // clr coincident with a fail: counter cleared, err_sticky set.
    step(0, 1, 0, 2'b01, 2'b00);
    step(0, 1, 0, 2'b00, 2'b00);
    chk("clrfail.pre_cnt", 64'(fail_cnt[CW-1:0]), 64'(1));
    step(0, 1, 1, 2'b01, 2'b00);
    step(0, 1, 1, 2'b00, 2'b00);
    chk("clrfail.fail", 64'(fail), 64'(2'b01));
    chk("clrfail.cnt",  64'(fail_cnt[CW-1:0]), 64'(0));
    chk("clrfail.err",  64'(err_sticky), 64'(1));

    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 31) == 0),
           NCH'($urandom),
           {($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
